// File: rtl/mips_step_ctrl.sv
// Single-step / run-N / free-run clock-enable controller for a MIPS core.
// Define STEP_CTRL_BREAKPOINT_EN to enable PC breakpoint halting.
module mips_step_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_btn,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_count,
  input  logic             bp_valid,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_current,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit_flag,
  output logic [31:0]      step_count
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StStep = 2'b01,
    StRun  = 2'b10,
    StHalt = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             btn_prev_q;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             free_run_q, free_run_d;
  logic             first_run_q, first_run_d;
  logic             bp_hit_q, bp_hit_d;
  logic [31:0]      step_count_q, step_count_d;
  logic             btn_edge;
  logic             bp_stop;

  assign btn_edge = sync_q[SYNC_STAGES-1] & ~btn_prev_q;

`ifdef STEP_CTRL_BREAKPOINT_EN
  // The first RUN cycle skips the compare so a run can leave a breakpoint PC.
  assign bp_stop = bp_valid && (pc_current == bp_addr) && (state_q == StRun) && !first_run_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_valid, bp_addr, pc_current};
  assign bp_stop   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    free_run_d   = free_run_q;
    first_run_d  = 1'b0;
    bp_hit_d     = bp_hit_q;
    cpu_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_edge) begin
          unique case (mode)
            2'b00: state_d = StStep;
            2'b01: begin
              if (run_count != '0) begin
                remaining_d = run_count;
                free_run_d  = 1'b0;
                first_run_d = 1'b1;
                state_d     = StRun;
              end
            end
            2'b10: begin
              free_run_d  = 1'b1;
              first_run_d = 1'b1;
              state_d     = StRun;
            end
            default: ;
          endcase
        end
      end
      StStep: begin
        cpu_en  = 1'b1;
        state_d = StIdle;
      end
      StRun: begin
        // Breakpoint takes priority over terminal count and the stop button.
        if (bp_stop) begin
          state_d  = StHalt;
          bp_hit_d = 1'b1;
        end else begin
          cpu_en = 1'b1;
          if (free_run_q) begin
            if (btn_edge) state_d = StHalt;
          end else begin
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (btn_edge) begin
          state_d    = StIdle;
          bp_hit_d   = 1'b0;
          free_run_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    step_count_d = step_count_q;
    if (cpu_en) step_count_d = step_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= '0;
      btn_prev_q   <= 1'b0;
      state_q      <= StIdle;
      remaining_q  <= '0;
      free_run_q   <= 1'b0;
      first_run_q  <= 1'b0;
      bp_hit_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], step_btn};
      btn_prev_q   <= sync_q[SYNC_STAGES-1];
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      free_run_q   <= free_run_d;
      first_run_q  <= first_run_d;
      bp_hit_q     <= bp_hit_d;
      step_count_q <= step_count_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == StHalt);
  assign bp_hit_flag = bp_hit_q;
  assign step_count  = step_count_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Self-checking bench for mips_step_ctrl: directed scenarios plus random
// transactions checked against a per-press pulse-count model.
module tb_mips_step_ctrl;
  localparam int unsigned CntW = 16;
  localparam int          Never = 1 << 30;

`ifdef STEP_CTRL_BREAKPOINT_EN
  localparam bit BpEn = 1'b1;
`else
  localparam bit BpEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            step_btn = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic [CntW-1:0] run_count = '0;
  logic            bp_valid = 1'b0;
  logic [31:0]     bp_addr = '0;
  logic [31:0]     pc_current = '0;
  logic            cpu_en;
  logic [1:0]      state;
  logic            halted;
  logic            bp_hit_flag;
  logic [31:0]     step_count;

  int checks = 0;
  int errors = 0;
  int unsigned m_steps = 0;

  always #5 clk = ~clk;

  mips_step_ctrl #(
    .SYNC_STAGES(2),
    .CNT_W      (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_btn   (step_btn),
    .mode       (mode),
    .run_count  (run_count),
    .bp_valid   (bp_valid),
    .bp_addr    (bp_addr),
    .pc_current (pc_current),
    .cpu_en     (cpu_en),
    .state      (state),
    .halted     (halted),
    .bp_hit_flag(bp_hit_flag),
    .step_count (step_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample cpu_en mid-cycle; the modelled CPU advances PC on enabled edges.
  task automatic tick(output logic en);
    @(negedge clk);
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en === 1'b1) pc_current = pc_current + 32'd4;
  endtask

  task automatic press_window(input int ncyc, output int pulses, output bit contig);
    logic en;
    int first = -1;
    int last = -1;
    pulses = 0;
    step_btn = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (i == 4) step_btn = 1'b0;
      if (i == 6) begin
        mode      = 2'($urandom_range(3));
        run_count = CntW'($urandom_range(7));
      end
      tick(en);
      if (en === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    contig = (pulses == 0) || (last - first + 1 == pulses);
  endtask

  // Start a free run, press again g cycles later; without a breakpoint, pulses == g.
  task automatic free_window(input int g, output int pulses, output bit contig);
    logic en;
    int first = -1;
    int last = -1;
    pulses = 0;
    step_btn = 1'b1;
    for (int i = 0; i < g + 16; i++) begin
      if (i == 4 || i == g + 4) step_btn = 1'b0;
      if (i == g) step_btn = 1'b1;
      if (i == 5) begin
        mode      = 2'($urandom_range(3));
        run_count = CntW'($urandom_range(7));
      end
      tick(en);
      if (en === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    contig = (pulses == 0) || (last - first + 1 == pulses);
  endtask

  task automatic check_post(input string tag, input int p, input int p_exp, input bit contig,
                            input logic [1:0] st_exp, input logic hit_exp);
    m_steps += p_exp;
    check({tag, "_pulses"}, 32'(p), 32'(p_exp));
    check({tag, "_contig"}, 32'(contig), 32'd1);
    check({tag, "_state"}, 32'(state), 32'(st_exp));
    check({tag, "_halted"}, 32'(halted), 32'(st_exp == 2'b11));
    check({tag, "_bphit"}, 32'(bp_hit_flag), 32'(hit_exp));
    check({tag, "_stepcnt"}, step_count, m_steps);
  endtask

  initial begin
    int p, p_exp, n, k, g, off, md;
    bit c, bv;
    logic en;
    logic [1:0] st_exp;
    logic hit_exp;

    #2 rst = 1'b0;
    #1;
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bphit", 32'(bp_hit_flag), 32'd0);
    check("rst_stepcnt", step_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(en);

    mode = 2'b00;
    press_window(12, p, c);
    check_post("single", p, 1, c, 2'b00, 1'b0);

    mode = 2'b01;
    run_count = CntW'(5);
    press_window(20, p, c);
    check_post("runn5", p, 5, c, 2'b11, 1'b0);
    press_window(12, p, c);
    check_post("runn5_exit", p, 0, c, 2'b00, 1'b0);

    mode = 2'b01;
    run_count = '0;
    press_window(12, p, c);
    check_post("runn0", p, 0, c, 2'b00, 1'b0);

`ifdef STEP_CTRL_BREAKPOINT_EN
    pc_current = 32'h0;
    bp_valid   = 1'b1;
    bp_addr    = 32'h0000_001C;
    mode       = 2'b10;
    press_window(30, p, c);
    check_post("bp_free", p, 7, c, 2'b11, 1'b1);
    check("bp_free_pc", pc_current, 32'h1C);
    press_window(12, p, c);
    check_post("bp_free_exit", p, 0, c, 2'b00, 1'b0);
    mode = 2'b10;
    free_window(10, p, c);
    check_post("bp_resume", p, 10, c, 2'b11, 1'b0);
    check("bp_resume_pc", pc_current, 32'h1C + 32'd40);
    press_window(12, p, c);
    check_post("bp_resume_exit", p, 0, c, 2'b00, 1'b0);

    bp_addr   = pc_current + 32'd8;
    mode      = 2'b01;
    run_count = CntW'(3);
    press_window(20, p, c);
    check_post("bp_runn3", p, 2, c, 2'b11, 1'b1);
    press_window(12, p, c);
    check_post("bp_runn3_exit", p, 0, c, 2'b00, 1'b0);
    bp_valid = 1'b0;
`endif

    for (int t = 0; t < 30; t++) begin
      md  = int'($urandom_range(3));
      n   = int'($urandom_range(6));
      off = int'($urandom_range(8));
      bv  = 1'($urandom_range(1));
      mode      = 2'(md);
      run_count = CntW'(n);
      bp_valid  = bv;
      bp_addr   = pc_current + 32'(4 * off);
      // Pulses issued before the breakpoint PC is reached; a breakpoint on the
      // starting PC never fires because the first RUN cycle ignores it.
      k = (BpEn && bv && off != 0) ? off : Never;
      if (md == 0) begin
        press_window(12, p, c);
        check_post("rnd_step", p, 1, c, 2'b00, 1'b0);
      end else if (md == 1) begin
        press_window(n + 14, p, c);
        p_exp   = (n < k) ? n : k;
        st_exp  = (n != 0) ? 2'b11 : 2'b00;
        hit_exp = (k < n);
        check_post("rnd_runn", p, p_exp, c, st_exp, hit_exp);
      end else if (md == 2) begin
        g = int'($urandom_range(20, 8));
        free_window(g, p, c);
        p_exp   = (g < k) ? g : k;
        // An early breakpoint halt lets the stop press fall into HALT and exit it.
        st_exp  = (k + 1 < g) ? 2'b00 : 2'b11;
        hit_exp = (k < g) && !(k + 1 < g);
        check_post("rnd_free", p, p_exp, c, st_exp, hit_exp);
      end else begin
        press_window(12, p, c);
        check_post("rnd_hold", p, 0, c, 2'b00, 1'b0);
      end
      if (state == 2'b11) begin
        press_window(12, p, c);
        check_post("rnd_exit", p, 0, c, 2'b00, 1'b0);
      end
    end

    bp_valid = 1'b0;
    mode     = 2'b10;
    step_btn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 4) step_btn = 1'b0;
      tick(en);
    end
    #2;
    check("pre_rst_cpu_en", 32'(cpu_en), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_cpu_en", 32'(cpu_en), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    check("async_rst_bphit", 32'(bp_hit_flag), 32'd0);
    check("async_rst_stepcnt", step_count, 32'd0);
    m_steps = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      tick(en);
      if (en === 1'b1) p++;
    end
    check("post_rst_pulses", 32'(p), 32'd0);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_stepcnt", step_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_step_ctrl.md
MIPS_STEP_CTRL -- requirements
Module: mips_step_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages in the step_btn synchronizer, legal range 2..4.
REQ-002 SHALL have parameter CNT_W, default 16: width of run_count and of the internal remaining-steps counter.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port step_btn, input, 1 bit: debounced button level; may be asynchronous to clk.
REQ-006 SHALL have port mode, input, 2 bits: 00 single-step, 01 run-N, 10 free-run, 11 hold.
REQ-007 SHALL have port run_count, input, CNT_W bits: number of steps issued in run-N mode.
REQ-008 SHALL have port bp_valid, input, 1 bit: breakpoint armed.
REQ-009 SHALL have port bp_addr, input, 32 bits: breakpoint PC.
REQ-010 SHALL have port pc_current, input, 32 bits: CPU PC.
REQ-011 SHALL have port cpu_en, output, 1 bit: CPU clock enable; the CPU advances exactly one step per cycle in which it is high.
REQ-012 SHALL have port state, output, 2 bits: 00 IDLE, 01 STEP, 10 RUN, 11 HALT.
REQ-013 SHALL have port halted, output, 1 bit: high while state is HALT.
REQ-014 SHALL have port bp_hit_flag, output, 1 bit: the last halt was caused by a breakpoint.
REQ-015 SHALL have port step_count, output, 32 bits: total cpu_en-high cycles since reset.

Function
REQ-016 SHALL synchronize step_btn through SYNC_STAGES flops and produce btn_edge, a one-cycle pulse on the synchronized rising edge; a level held high produces exactly one pulse.
REQ-017 SHALL drive cpu_en combinationally as (state==STEP) or (state==RUN and not bp_stop).
REQ-018 SHALL define bp_stop as bp_valid and pc_current==bp_addr and state==RUN and not first_run_cycle.
REQ-019 SHALL sample mode and run_count only on btn_edge in IDLE; changes during STEP, RUN or HALT SHALL be ignored.
REQ-020 In IDLE, btn_edge with mode 00 SHALL go to STEP.
REQ-021 In IDLE, btn_edge with mode 01 and run_count 0 SHALL remain in IDLE.
REQ-022 In IDLE, btn_edge with mode 01 and run_count nonzero SHALL load remaining=run_count and go to RUN.
REQ-023 In IDLE, btn_edge with mode 10 SHALL go to RUN with free-run set.
REQ-024 In IDLE, btn_edge with mode 11 SHALL be ignored.
REQ-025 STEP SHALL last exactly one cycle and then return to IDLE; the breakpoint SHALL be ignored in STEP.
REQ-026 In RUN (run-N), remaining SHALL decrement on each cpu_en cycle; the cycle in which remaining==1 SHALL be the last enabled cycle, followed by HALT; exactly run_count pulses SHALL be issued.
REQ-027 In RUN (free-run), a btn_edge SHALL go to HALT next cycle; cpu_en SHALL stay high in that edge cycle.
REQ-028 In RUN, bp_stop SHALL suppress cpu_en in the same cycle, go to HALT, and set bp_hit_flag.
REQ-029 first_run_cycle SHALL be high only in the first RUN cycle, so a run can resume from a breakpoint PC.
REQ-030 If bp_stop and a run-N terminal count or a free-run btn_edge occur in the same cycle, bp_stop SHALL win: no pulse, and bp_hit_flag set.
REQ-031 In HALT, btn_edge SHALL return the block to IDLE without issuing a step; bp_hit_flag SHALL clear on leaving HALT.
REQ-032 step_count SHALL increment on every cpu_en cycle and wrap from 0xFFFFFFFF to 0.

Reset
REQ-033 rst low SHALL asynchronously force state IDLE, cpu_en 0, halted 0, bp_hit_flag 0, step_count 0, remaining 0, free-run 0 and all synchronizer flops to 0.
REQ-034 Reset asserted mid-RUN SHALL drop cpu_en immediately; no pulse SHALL be issued in the first cycle after release.

Configuration
REQ-035 Macro STEP_CTRL_BREAKPOINT_EN defined SHALL enable the breakpoint behaviour of REQ-018, REQ-028 and REQ-030.
REQ-036 Macro STEP_CTRL_BREAKPOINT_EN undefined SHALL tie bp_stop to 0 and bp_hit_flag to 0, and SHALL ignore bp_valid, bp_addr and pc_current; the ports SHALL remain present.

Verification
REQ-037 Mode 00, one button press -> exactly 1 cpu_en pulse, state IDLE, step_count=1.
REQ-038 Mode 01, run_count=5 -> 5 consecutive cpu_en cycles, then HALT, halted=1; second press -> IDLE with no pulse.
REQ-039 Mode 01, run_count=0, press -> no pulse, state stays IDLE.
REQ-040 Breakpoint build, bp_addr=0x0000001C, pc stepping by 4 from 0 -> 7 pulses, HALT with bp_hit_flag=1; press and press again -> run resumes past 0x1C.
REQ-041 Mode 10, free-run, rst low after 100 cycles -> cpu_en 0 asynchronously; all outputs reset; no pulse after release.
REQ-042 Breakpoint build, mode 01 run_count=3 with breakpoint on the 3rd PC -> 2 pulses, then HALT with bp_hit_flag=1.
